// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and pipeline-register field layouts, also imported
// by the pipeline control unit.
package y86_pkg;

   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] STAT_HLT = 4'h2;
   localparam logic [3:0] STAT_ADR = 4'h3;
   localparam logic [3:0] STAT_INS = 4'h4;

   localparam logic [3:0] I_HALT = 4'h0;
   localparam logic [3:0] I_NOP  = 4'h1;
   localparam logic [3:0] I_JXX  = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8;
   localparam logic [3:0] I_RET  = 4'h9;
   localparam logic [3:0] I_PUSH = 4'hA;
   localparam logic [3:0] I_POP  = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] val_c;
      logic [63:0] val_p;
   } d_reg_t;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
      logic [63:0] val_c;
      logic [63:0] val_a;
      logic [63:0] val_b;
   } e_reg_t;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [63:0] val_e;
      logic [63:0] val_a;
   } m_reg_t;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [63:0] val_e;
      logic [63:0] val_m;
   } w_reg_t;

   localparam d_reg_t D_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                   ra: RNONE, rb: RNONE, val_c: '0, val_p: '0};
   localparam e_reg_t E_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                   dst_e: RNONE, dst_m: RNONE, src_a: RNONE,
                                   src_b: RNONE, val_c: '0, val_a: '0, val_b: '0};
   localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                   dst_e: RNONE, dst_m: RNONE, val_e: '0, val_a: '0};
   localparam w_reg_t W_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, dst_e: RNONE,
                                   dst_m: RNONE, val_e: '0, val_m: '0};

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: stall holds, bubble loads BUBBLE, reset
// asynchronously forces BUBBLE. Stall wins over bubble.
module pipe_stage_reg #(
   parameter int unsigned           WIDTH  = 1,
   parameter logic [WIDTH-1:0]      BUBBLE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             bubble,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q <= BUBBLE;
      else if (stall)  q <= q;
      else if (bubble) q <= BUBBLE;
      else             q <= d;
   end

endmodule

// File: rtl/pipe_regs.sv
// Y86-64 F/D/E/M/W pipeline registers with per-stage stall/bubble control
// and a sticky flag for conflicting D-stage controls.
module pipe_regs
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        F_stall,
   input  logic        D_stall,
   input  logic        D_bubble,
   input  logic        E_bubble,
   input  logic        M_bubble,
   input  logic        W_stall,
   input  logic [63:0] f_predPC,
   output logic [63:0] F_predPC,
   input  logic [3:0]  f_stat,
   input  logic [3:0]  f_icode,
   input  logic [3:0]  f_ifun,
   input  logic [3:0]  f_rA,
   input  logic [3:0]  f_rB,
   input  logic [63:0] f_valC,
   input  logic [63:0] f_valP,
   output logic [3:0]  D_stat,
   output logic [3:0]  D_icode,
   output logic [3:0]  D_ifun,
   output logic [3:0]  D_rA,
   output logic [3:0]  D_rB,
   output logic [63:0] D_valC,
   output logic [63:0] D_valP,
   input  logic [3:0]  d_stat,
   input  logic [3:0]  d_icode,
   input  logic [3:0]  d_ifun,
   input  logic [3:0]  d_dstE,
   input  logic [3:0]  d_dstM,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [63:0] d_valC,
   input  logic [63:0] d_valA,
   input  logic [63:0] d_valB,
   output logic [3:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   input  logic [3:0]  e_stat,
   input  logic [3:0]  e_icode,
   input  logic        e_Cnd,
   input  logic [3:0]  e_dstE,
   input  logic [3:0]  e_dstM,
   input  logic [63:0] e_valE,
   input  logic [63:0] e_valA,
   output logic [3:0]  M_stat,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  m_icode,
   input  logic [3:0]  m_dstE,
   input  logic [3:0]  m_dstM,
   input  logic [63:0] m_valE,
   input  logic [63:0] m_valM,
   output logic [3:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic        ctrl_err
);

   d_reg_t d_in, d_q;
   e_reg_t e_in, e_q;
   m_reg_t m_in, m_q;
   w_reg_t w_in, w_q;

   assign d_in = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                   val_c: f_valC, val_p: f_valP};
   assign e_in = '{stat: d_stat, icode: d_icode, ifun: d_ifun, dst_e: d_dstE,
                   dst_m: d_dstM, src_a: d_srcA, src_b: d_srcB, val_c: d_valC,
                   val_a: d_valA, val_b: d_valB};
   assign m_in = '{stat: e_stat, icode: e_icode, cnd: e_Cnd, dst_e: e_dstE,
                   dst_m: e_dstM, val_e: e_valE, val_a: e_valA};
   assign w_in = '{stat: m_stat, icode: m_icode, dst_e: m_dstE, dst_m: m_dstM,
                   val_e: m_valE, val_m: m_valM};

   pipe_stage_reg #(.WIDTH(64), .BUBBLE('0)) u_f (
      .clk(clk), .rst_n(rst_n), .stall(F_stall), .bubble(1'b0),
      .d(f_predPC), .q(F_predPC)
   );

   pipe_stage_reg #(.WIDTH($bits(d_reg_t)), .BUBBLE(D_BUBBLE)) u_d (
      .clk(clk), .rst_n(rst_n), .stall(D_stall), .bubble(D_bubble),
      .d(d_in), .q(d_q)
   );

   pipe_stage_reg #(.WIDTH($bits(e_reg_t)), .BUBBLE(E_BUBBLE)) u_e (
      .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(E_bubble),
      .d(e_in), .q(e_q)
   );

   pipe_stage_reg #(.WIDTH($bits(m_reg_t)), .BUBBLE(M_BUBBLE)) u_m (
      .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(M_bubble),
      .d(m_in), .q(m_q)
   );

   pipe_stage_reg #(.WIDTH($bits(w_reg_t)), .BUBBLE(W_BUBBLE)) u_w (
      .clk(clk), .rst_n(rst_n), .stall(W_stall), .bubble(1'b0),
      .d(w_in), .q(w_q)
   );

   // Sticky until reset: a stall+bubble request on D is a control-unit bug.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    ctrl_err <= 1'b0;
      else if (D_stall && D_bubble)  ctrl_err <= 1'b1;
   end

   assign D_stat  = d_q.stat;
   assign D_icode = d_q.icode;
   assign D_ifun  = d_q.ifun;
   assign D_rA    = d_q.ra;
   assign D_rB    = d_q.rb;
   assign D_valC  = d_q.val_c;
   assign D_valP  = d_q.val_p;

   assign E_stat  = e_q.stat;
   assign E_icode = e_q.icode;
   assign E_ifun  = e_q.ifun;
   assign E_dstE  = e_q.dst_e;
   assign E_dstM  = e_q.dst_m;
   assign E_srcA  = e_q.src_a;
   assign E_srcB  = e_q.src_b;
   assign E_valC  = e_q.val_c;
   assign E_valA  = e_q.val_a;
   assign E_valB  = e_q.val_b;

   assign M_stat  = m_q.stat;
   assign M_icode = m_q.icode;
   assign M_Cnd   = m_q.cnd;
   assign M_dstE  = m_q.dst_e;
   assign M_dstM  = m_q.dst_m;
   assign M_valE  = m_q.val_e;
   assign M_valA  = m_q.val_a;

   assign W_stat  = w_q.stat;
   assign W_icode = w_q.icode;
   assign W_dstE  = w_q.dst_e;
   assign W_dstM  = w_q.dst_m;
   assign W_valE  = w_q.val_e;
   assign W_valM  = w_q.val_m;

endmodule

// File: tb/tb_pipe_regs.sv
// Directed self-checking bench for pipe_regs with hand-computed expectations.
module tb_pipe_regs;

   logic        clk, rst_n;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
   logic [63:0] f_predPC, F_predPC;
   logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
   logic [63:0] f_valC, f_valP;
   logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
   logic [63:0] d_valC, d_valA, d_valB;
   logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
   logic        e_Cnd;
   logic [63:0] e_valE, e_valA;
   logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
   logic        M_Cnd;
   logic [63:0] M_valE, M_valA;
   logic [3:0]  m_stat, m_icode, m_dstE, m_dstM;
   logic [63:0] m_valE, m_valM;
   logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic        ctrl_err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   localparam logic [147:0] D_BUB = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
   localparam logic [219:0] E_BUB = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                                     64'h0, 64'h0, 64'h0};
   localparam logic [144:0] M_BUB = {4'h1, 4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0};
   localparam logic [143:0] W_BUB = {4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0};

   pipe_regs dut (
      .clk(clk), .rst_n(rst_n),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
      .f_predPC(f_predPC), .F_predPC(F_predPC),
      .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
      .f_valC(f_valC), .f_valP(f_valP),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_dstE(d_dstE),
      .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
      .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
      .e_dstM(e_dstM), .e_valE(e_valE), .e_valA(e_valA),
      .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_dstE(M_dstE),
      .M_dstM(M_dstM), .M_valE(M_valE), .M_valA(M_valA),
      .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
      .m_valE(m_valE), .m_valM(m_valM),
      .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM),
      .ctrl_err(ctrl_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_controls();
      F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0; M_bubble = 0; W_stall = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_controls();
      f_predPC = 64'h3333;
      f_stat = 4'h2; f_icode = 4'h3; f_ifun = 4'h4; f_rA = 4'h5; f_rB = 4'h6;
      f_valC = 64'h1111; f_valP = 64'h2222;
      d_stat = 4'h2; d_icode = 4'h3; d_ifun = 4'h4; d_dstE = 4'h5; d_dstM = 4'h6;
      d_srcA = 4'h7; d_srcB = 4'h8; d_valC = 64'hAA; d_valA = 64'hBB; d_valB = 64'hCC;
      e_stat = 4'h2; e_icode = 4'h3; e_Cnd = 1; e_dstE = 4'h4; e_dstM = 4'h5;
      e_valE = 64'hDD; e_valA = 64'hEE;
      m_stat = 4'h2; m_icode = 4'h3; m_dstE = 4'h4; m_dstM = 4'h5;
      m_valE = 64'h77; m_valM = 64'h88;
      tick();
      vectors++;
      if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== D_BUB) begin
         miscompares++; $display("FAIL reset_hold_D: got %h want %h",
            {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, D_BUB);
      end
      rst_n = 1;
      D_stall = 1; D_bubble = 1;
      tick();
      clear_controls();
      tick();
      vectors++;
      if (ctrl_err !== 1'b1 || D_icode !== 4'h3) begin
         miscompares++; $display("FAIL reset_preload: ctrl_err %b D_icode %h want 1 3",
            ctrl_err, D_icode);
      end
      // Assert reset between edges and look before any clock edge arrives.
      #2 rst_n = 0;
      #1;
      vectors++;
      if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== D_BUB) begin
         miscompares++; $display("FAIL async_reset_D: got %h want %h",
            {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, D_BUB);
      end
      vectors++;
      if ({E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA,
           E_valB} !== E_BUB) begin
         miscompares++; $display("FAIL async_reset_E: got %h want %h",
            {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA,
             E_valB}, E_BUB);
      end
      vectors++;
      if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM, M_valE, M_valA} !== M_BUB) begin
         miscompares++; $display("FAIL async_reset_M: got %h want %h",
            {M_stat, M_icode, M_Cnd, M_dstE, M_dstM, M_valE, M_valA}, M_BUB);
      end
      vectors++;
      if ({W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM} !== W_BUB) begin
         miscompares++; $display("FAIL async_reset_W: got %h want %h",
            {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM}, W_BUB);
      end
      vectors++;
      if (F_predPC !== 64'h0 || ctrl_err !== 1'b0) begin
         miscompares++; $display("FAIL async_reset_F_err: F_predPC %h ctrl_err %b want 0 0",
            F_predPC, ctrl_err);
      end
      #2 rst_n = 1;
   endtask

   task automatic test_pass_through();
      clear_controls();
      f_predPC = 64'h1A;
      f_stat = 4'h1; f_icode = 4'h6; f_ifun = 4'h0; f_rA = 4'h2; f_rB = 4'h3;
      f_valC = 64'h10; f_valP = 64'h1A;
      d_stat = 4'h1; d_icode = 4'h6; d_ifun = 4'h1; d_dstE = 4'h3; d_dstM = 4'hF;
      d_srcA = 4'h2; d_srcB = 4'h3; d_valC = 64'h10; d_valA = 64'h5; d_valB = 64'h7;
      e_stat = 4'h1; e_icode = 4'h6; e_Cnd = 1; e_dstE = 4'h3; e_dstM = 4'hF;
      e_valE = 64'hC; e_valA = 64'h5;
      m_stat = 4'h1; m_icode = 4'h6; m_dstE = 4'h3; m_dstM = 4'hF;
      m_valE = 64'hC; m_valM = 64'h0;
      tick();
      vectors++;
      if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !==
          {4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h10, 64'h1A} || F_predPC !== 64'h1A) begin
         miscompares++; $display("FAIL pass_D: got %h F %h want icode 6 valC 10 F 1a",
            {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, F_predPC);
      end
      tick();
      vectors++;
      if ({E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA,
           E_valB} !== {4'h1, 4'h6, 4'h1, 4'h3, 4'hF, 4'h2, 4'h3, 64'h10, 64'h5, 64'h7})
      begin
         miscompares++; $display("FAIL pass_E: got %h", {E_stat, E_icode, E_ifun, E_dstE,
            E_dstM, E_srcA, E_srcB, E_valC, E_valA, E_valB});
      end
      vectors++;
      if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM, M_valE, M_valA} !==
          {4'h1, 4'h6, 1'b1, 4'h3, 4'hF, 64'hC, 64'h5}) begin
         miscompares++; $display("FAIL pass_M: got %h", {M_stat, M_icode, M_Cnd, M_dstE,
            M_dstM, M_valE, M_valA});
      end
      vectors++;
      if ({W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM} !==
          {4'h1, 4'h6, 4'h3, 4'hF, 64'hC, 64'h0}) begin
         miscompares++; $display("FAIL pass_W: got %h", {W_stat, W_icode, W_dstE, W_dstM,
            W_valE, W_valM});
      end
   endtask

   task automatic test_load_use();
      clear_controls();
      f_predPC = 64'h40; f_icode = 4'hB; f_rA = 4'h4; f_valC = 64'h20;
      tick();
      F_stall = 1; D_stall = 1; E_bubble = 1;
      f_predPC = 64'h48; f_icode = 4'h2; f_rA = 4'h9; f_valC = 64'h30;
      d_icode = 4'hB; d_dstM = 4'h4;
      tick();
      vectors++;
      if (F_predPC !== 64'h40 || D_icode !== 4'hB || D_rA !== 4'h4 || D_valC !== 64'h20)
      begin
         miscompares++; $display("FAIL load_use_hold: F %h D_icode %h D_rA %h D_valC %h want 40 b 4 20",
            F_predPC, D_icode, D_rA, D_valC);
      end
      vectors++;
      if ({E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA,
           E_valB} !== E_BUB) begin
         miscompares++; $display("FAIL load_use_E_bubble: got icode %h dstM %h want 1 f",
            E_icode, E_dstM);
      end
      clear_controls();
      tick();
      vectors++;
      if (F_predPC !== 64'h48 || D_icode !== 4'h2 || E_icode !== 4'hB || E_dstM !== 4'h4)
      begin
         miscompares++; $display("FAIL load_use_release: F %h D %h E %h dstM %h want 48 2 b 4",
            F_predPC, D_icode, E_icode, E_dstM);
      end
   endtask

   task automatic test_mispredict();
      clear_controls();
      e_icode = 4'h6; e_Cnd = 1;
      tick();
      D_bubble = 1; E_bubble = 1;
      e_stat = 4'h1; e_icode = 4'h7; e_Cnd = 0; e_valA = 64'h99;
      tick();
      vectors++;
      if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== D_BUB ||
          E_icode !== 4'h1 || E_srcA !== 4'hF) begin
         miscompares++; $display("FAIL mispredict_DE: D_icode %h D_rA %h E_icode %h want 1 f 1",
            D_icode, D_rA, E_icode);
      end
      vectors++;
      if (M_icode !== 4'h7 || M_Cnd !== 1'b0 || M_valA !== 64'h99) begin
         miscompares++; $display("FAIL mispredict_M: icode %h Cnd %b valA %h want 7 0 99",
            M_icode, M_Cnd, M_valA);
      end
      clear_controls();
   endtask

   task automatic test_conflict();
      clear_controls();
      f_icode = 4'h3;
      tick();
      D_stall = 1; D_bubble = 1; f_icode = 4'h5;
      tick();
      vectors++;
      if (D_icode !== 4'h3 || ctrl_err !== 1'b1) begin
         miscompares++; $display("FAIL conflict: D_icode %h ctrl_err %b want 3 1",
            D_icode, ctrl_err);
      end
      clear_controls();
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (ctrl_err !== 1'b1 || D_icode !== 4'h5) begin
            miscompares++; $display("FAIL conflict_sticky[%0d]: ctrl_err %b D_icode %h want 1 5",
               i, ctrl_err, D_icode);
         end
      end
      #2 rst_n = 0;
      #1;
      vectors++;
      if (ctrl_err !== 1'b0) begin
         miscompares++; $display("FAIL conflict_clear: ctrl_err %b want 0", ctrl_err);
      end
      #2 rst_n = 1;
   endtask

   task automatic test_exception_drain();
      clear_controls();
      e_stat = 4'h1; e_icode = 4'h4;
      m_stat = 4'h1; m_icode = 4'h4; m_dstE = 4'h2; m_dstM = 4'hF;
      m_valE = 64'h44; m_valM = 64'h55;
      tick();
      M_bubble = 1; W_stall = 1;
      m_stat = 4'h3; m_icode = 4'h5; m_dstE = 4'h6; m_valE = 64'h66; m_valM = 64'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM, M_valE, M_valA} !== M_BUB ||
             {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM} !==
             {4'h1, 4'h4, 4'h2, 4'hF, 64'h44, 64'h55}) begin
            miscompares++; $display("FAIL drain[%0d]: M_icode %h W %h want M 1 W stat1 icode4 valM 55",
               i, M_icode, {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM});
         end
      end
      clear_controls();
      tick();
      vectors++;
      if (W_stat !== 4'h3 || W_icode !== 4'h5 || W_valM !== 64'h77 || M_icode !== 4'h4)
      begin
         miscompares++; $display("FAIL drain_release: W_stat %h W_icode %h W_valM %h M_icode %h want 3 5 77 4",
            W_stat, W_icode, W_valM, M_icode);
      end
   endtask

   task automatic test_reset_mid_stall();
      clear_controls();
      f_icode = 4'h8; f_predPC = 64'h100;
      tick();
      F_stall = 1; D_stall = 1;
      #2 rst_n = 0;
      #2 rst_n = 1;
      tick();
      vectors++;
      if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== D_BUB ||
          F_predPC !== 64'h0) begin
         miscompares++; $display("FAIL reset_mid_stall: D_icode %h F %h want 1 0",
            D_icode, F_predPC);
      end
      clear_controls();
      tick();
      vectors++;
      if (D_icode !== 4'h8 || F_predPC !== 64'h100) begin
         miscompares++; $display("FAIL reset_mid_stall_release: D_icode %h F %h want 8 100",
            D_icode, F_predPC);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] pcs [4];
      pcs[0] = 64'hDEAD_BEEF_0000_0001;
      pcs[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      pcs[2] = 64'h0000_0000_0000_0000;
      pcs[3] = 64'h8000_0000_0000_0008;
      clear_controls();
      for (int i = 0; i < 4; i++) begin
         f_predPC = pcs[i];
         f_valP = ~pcs[i];
         tick();
         vectors++;
         if (F_predPC !== pcs[i] || D_valP !== ~pcs[i]) begin
            miscompares++; $display("FAIL back_to_back[%0d]: F %h D_valP %h want %h %h",
               i, F_predPC, D_valP, pcs[i], ~pcs[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_mispredict();
      test_conflict();
      test_exception_drain();
      test_reset_mid_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
